// File: rtl/lab_pkg.sv
// Shared constants for the lab blocks.
package lab_pkg;

  // Debounce window of 10 ms with a 12 MHz system clock.
  localparam int unsigned DebounceCycles12MHz = 120000;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous single-bit level inputs, reset to 0.
module sync2 #(
  parameter int unsigned width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_n_async_i,
  input  logic [width_p-1:0] d_i,
  output logic [width_p-1:0] q_o
);

  logic [width_p-1:0] meta_q;
  logic [width_p-1:0] sync_q;

  always_ff @(posedge clk_i or negedge reset_n_async_i) begin
    if (!reset_n_async_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/button_debounce.sv
// Per-channel button debouncer: synchronize, require a steady new level for
// stable_cycles_p consecutive edges, then emit registered press/release pulses.
module button_debounce
  import lab_pkg::*;
#(
  parameter int unsigned width_p         = 3,
  parameter int unsigned stable_cycles_p = DebounceCycles12MHz
) (
  input  logic               clk_i,
  input  logic               reset_n_async_i,
  input  logic [width_p-1:0] button_async_unsafe_i,
  output logic [width_p-1:0] button_o,
  output logic [width_p-1:0] press_o,
  output logic [width_p-1:0] release_o
);

  localparam int unsigned CntW = (stable_cycles_p > 1) ? $clog2(stable_cycles_p) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(stable_cycles_p - 1);

  logic [width_p-1:0] sync_val;

  sync2 #(
    .width_p(width_p)
  ) u_sync2 (
    .clk_i          (clk_i),
    .reset_n_async_i(reset_n_async_i),
    .d_i            (button_async_unsafe_i),
    .q_o            (sync_val)
  );

  for (genvar i = 0; i < int'(width_p); i++) begin : g_chan
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            state_q, state_d;
    logic            press_q, press_d;
    logic            release_q, release_d;

    // Counter saturates at CntMax by accepting the new level, so it never wraps.
    always_comb begin
      cnt_d     = '0;
      state_d   = state_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (sync_val[i] != state_q) begin
        if (cnt_q == CntMax) begin
          state_d   = sync_val[i];
          press_d   = sync_val[i];
          release_d = ~sync_val[i];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk_i or negedge reset_n_async_i) begin
      if (!reset_n_async_i) begin
        cnt_q     <= '0;
        state_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        cnt_q     <= cnt_d;
        state_q   <= state_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    assign button_o[i]  = state_q;
    assign press_o[i]   = press_q;
    assign release_o[i] = release_q;
  end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 The block SHALL have parameter width_p, default 3, giving the number of independent button channels.
REQ-002 The block SHALL have parameter stable_cycles_p, default 120000 (10 ms at 12 MHz), giving the consecutive cycles an input must hold a new level before it is accepted; legal range 2..2^24.
REQ-003 The block SHALL have port clk_i  input  1  single system clock; all state on rising edge.
REQ-004 The block SHALL have port reset_n_async_i  input  1  reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port button_async_unsafe_i  input  width_p  raw active-high buttons; unsynchronized, bouncing.
REQ-006 The block SHALL have port button_o  output  width_p  debounced, synchronized level per channel.
REQ-007 The block SHALL have port press_o  output  width_p  one-cycle pulse per channel when button_o rises.
REQ-008 The block SHALL have port release_o  output  width_p  one-cycle pulse per channel when button_o falls.

Function
REQ-009 Each channel SHALL pass its input through a two-flop synchronizer; the second-flop output is the channel's sync value d.
REQ-010 Each channel SHALL hold a state bit (driving button_o) and a counter cnt of width $clog2(stable_cycles_p).
REQ-011 Per edge, when d equals state, cnt SHALL load 0.
REQ-012 Per edge, when d differs from state and cnt < stable_cycles_p-1, cnt SHALL increment by 1.
REQ-013 Per edge, when d differs from state and cnt == stable_cycles_p-1, state SHALL load d and cnt SHALL load 0.
REQ-014 Acceptance SHALL therefore require d to differ from state on stable_cycles_p consecutive edges.
REQ-015 Any return of d to state before acceptance SHALL discard progress; cnt restarts from 0 on the next difference.
REQ-016 Latency SHALL be stable_cycles_p+2 rising edges from the first edge sampling a new steady input level to the edge where button_o changes.
REQ-017 press_o[i] SHALL be registered and asserted for exactly the one cycle in which button_o[i] first reads 1 after reading 0.
REQ-018 release_o[i] SHALL be registered and asserted for exactly the one cycle in which button_o[i] first reads 0 after reading 1.
REQ-019 press_o[i] and release_o[i] SHALL never be asserted together.
REQ-020 The counter SHALL never wrap; it saturates by rule REQ-013.
REQ-021 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each be accepted on their own schedule.
REQ-022 All outputs SHALL be driven directly from flops, with no combinational path from inputs.

Reset
REQ-023 Asserting reset_n_async_i low SHALL immediately clear synchronizer flops, state, cnt, button_o, press_o and release_o to 0, independent of clk_i.
REQ-024 Reset asserted mid-count SHALL discard the count; no pulse SHALL be emitted for the aborted transition.
REQ-025 After deassertion, a button held high throughout reset SHALL be accepted as a press after the normal REQ-016 latency, producing one press_o pulse.

Structure
REQ-026 Shared package lab_pkg SHALL hold the constant for default debounce cycles at 12 MHz (120000); no typedefs are required.
REQ-027 The two-flop synchronizer SHALL be a separate sub-module sync2 with a width parameter, reset value 0, and the same clock and reset ports.
REQ-028 Debounce logic SHALL be a generate loop over width_p channels within button_debounce.

Verification (stable_cycles_p overridden to 4)
REQ-029 Reset, then hold input[0]=1 steady -> button_o[0]=1 on the 6th edge after the first sampling edge; press_o[0] high for exactly that cycle.
REQ-030 With button_o[0]=1, drive input[0] pattern 0,1,0,1 one cycle each, then hold 1 -> button_o[0] stays 1; no pulses.
REQ-031 With button_o[0]=1, drive input[0]=0 for 3 cycles, then 1 -> no release; then hold 0 -> release_o[0] single pulse 6 edges later.
REQ-032 Drive inputs 3'b101 simultaneously -> button_o=3'b101 on the same edge; press_o=3'b101 for one cycle.
REQ-033 Assert reset after 2 counting cycles -> all outputs 0 immediately; hold input through reset -> press after 6 edges post-release, exactly one pulse.
REQ-034 Random bounce bursts shorter than 4 cycles per channel for 10^4 cycles -> no pulses; the press_o and release_o counts match the scoreboard model.
